// File: rtl/mask_stream_engine_pkg.sv
// Shared constants for the mask stream engine: mode and FSM state encodings.
package mask_stream_engine_pkg;

  // Masking modes carried on the 2-bit mode port.
  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_KEEP_IN  = 2'd1;
  localparam logic [1:0] MODE_KEEP_OUT = 2'd2;
  localparam logic [1:0] MODE_DIM_OUT  = 2'd3;

  // Engine FSM state encodings.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ACTIVE    = 2'd1;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

  // Number of colour channels packed into one pixel (R in MSBs).
  localparam int unsigned NUM_CH = 3;

endpackage

// File: rtl/mask_window_cmp.sv
// Combinational rectangular-window membership test.
// Ports: row/col     - pixel coordinate under test
//        row_off     - window top row,  col_off - window left column
//        inside_c    - 1 when (row,col) lies inside the MASK_H x MASK_W window
module mask_window_cmp
  import mask_stream_engine_pkg::*;
#(
  parameter int unsigned ROW_W  = 8,
  parameter int unsigned COL_W  = 9,
  parameter int unsigned MASK_W = 64,
  parameter int unsigned MASK_H = 64
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row_off,
  input  logic [COL_W-1:0] col_off,
  output logic             inside_c
);

  localparam int unsigned RW1 = ROW_W + 1;
  localparam int unsigned CW1 = COL_W + 1;

  logic [RW1-1:0] row_last;
  logic [CW1-1:0] col_last;

  // Last row/col of the window, one bit wider so a window past the edge clips instead of wrapping.
  always_comb begin
    row_last = RW1'(row_off) + RW1'(MASK_H - 1);
    col_last = CW1'(col_off) + CW1'(MASK_W - 1);
    inside_c = (row >= row_off) && (RW1'(row) <= row_last) &&
               (col >= col_off) && (CW1'(col) <= col_last);
  end

endmodule

// File: rtl/mask_stream_engine.sv
// Raster pixel stream masker writing into a double-buffered VGA frame store.
// Ports: clk/rst_n (sync active-low); en run enable; mode/mask_row_off/mask_col_off
//        window config (shadowed at frame start); in_valid/in_ready/in_sof/in_pixel
//        input stream; vblank VGA blanking level; wr_en/wr_bank/wr_row/wr_col/wr_data
//        frame-store write port; disp_bank displayed bank; frame_done swap pulse;
//        sync_err sticky SOF mismatch; busy engine not idle.
module mask_stream_engine
  import mask_stream_engine_pkg::*;
#(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned ROW_W  = 8,
  parameter int unsigned COL_W  = 9,
  parameter int unsigned PIX_W  = 12,
  parameter int unsigned MASK_W = 64,
  parameter int unsigned MASK_H = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [ROW_W-1:0] mask_row_off,
  input  logic [COL_W-1:0] mask_col_off,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             vblank,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [PIX_W-1:0] wr_data,
  output logic             disp_bank,
  output logic             frame_done,
  output logic             sync_err,
  output logic             busy
);

  localparam int unsigned CH_W = PIX_W / NUM_CH;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  logic [1:0]       state_q,      state_d;
  logic [1:0]       mode_sh_q,    mode_sh_d;
  logic [ROW_W-1:0] roff_sh_q,    roff_sh_d;
  logic [COL_W-1:0] coff_sh_q,    coff_sh_d;
  logic [ROW_W-1:0] row_q,        row_d;
  logic [COL_W-1:0] col_q,        col_d;
  logic             in_ready_q,   in_ready_d;
  logic             busy_q,       busy_d;
  logic             disp_bank_q,  disp_bank_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q,   sync_err_d;

  logic             s1_valid_q,   s1_valid_d;
  logic [PIX_W-1:0] s1_pixel_q,   s1_pixel_d;
  logic [ROW_W-1:0] s1_row_q,     s1_row_d;
  logic [COL_W-1:0] s1_col_q,     s1_col_d;
  logic             s1_inside_q,  s1_inside_d;

  logic             wr_en_q,      wr_en_d;
  logic             wr_bank_q,    wr_bank_d;
  logic [ROW_W-1:0] wr_row_q,     wr_row_d;
  logic [COL_W-1:0] wr_col_q,     wr_col_d;
  logic [PIX_W-1:0] wr_data_q,    wr_data_d;

  logic             accept_c;
  logic             at_origin_c;
  logic             pipe_empty_c;
  logic             inside_c;
  logic [ROW_W-1:0] eff_row_c;
  logic [COL_W-1:0] eff_col_c;
  logic [PIX_W-1:0] dimmed_c;

  // Window membership of the pixel being accepted, against the shadowed offsets.
  mask_window_cmp #(
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .MASK_W (MASK_W),
    .MASK_H (MASK_H)
  ) u_window_cmp (
    .row      (eff_row_c),
    .col      (eff_col_c),
    .row_off  (roff_sh_q),
    .col_off  (coff_sh_q),
    .inside_c (inside_c)
  );

  // FSM next state, raster counters, shadows and bank control.
  always_comb begin
    state_d      = state_q;
    mode_sh_d    = mode_sh_q;
    roff_sh_d    = roff_sh_q;
    coff_sh_d    = coff_sh_q;
    row_d        = row_q;
    col_d        = col_q;
    disp_bank_d  = disp_bank_q;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err_q;

    accept_c     = in_valid & in_ready_q;
    at_origin_c  = (row_q == '0) && (col_q == '0);
    // An SOF pixel always lands at (0,0), restarting the frame in the same bank.
    eff_row_c    = in_sof ? '0 : row_q;
    eff_col_c    = in_sof ? '0 : col_q;
    pipe_empty_c = ~s1_valid_q & ~wr_en_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_ACTIVE;
          mode_sh_d = mode;
          roff_sh_d = mask_row_off;
          coff_sh_d = mask_col_off;
          row_d     = '0;
          col_d     = '0;
        end
      end
      ST_ACTIVE: begin
        if (accept_c) begin
          // SOF present away from origin, or missing at origin.
          if (in_sof != at_origin_c) begin
            sync_err_d = 1'b1;
          end
          if (eff_col_c == COL_LAST) begin
            col_d = '0;
            if (eff_row_c == ROW_LAST) begin
              row_d   = '0;
              state_d = ST_WAIT_SWAP;
            end else begin
              row_d = eff_row_c + ROW_W'(1);
            end
          end else begin
            col_d = eff_col_c + COL_W'(1);
            row_d = eff_row_c;
          end
        end
      end
      ST_WAIT_SWAP: begin
        // Swap only once every write of this frame has left the pipe, during blanking.
        if (pipe_empty_c && vblank) begin
          disp_bank_d  = ~disp_bank_q;
          frame_done_d = 1'b1;
          if (en) begin
            state_d   = ST_ACTIVE;
            mode_sh_d = mode;
            roff_sh_d = mask_row_off;
            coff_sh_d = mask_col_off;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_ACTIVE);
    busy_d     = (state_d != ST_IDLE);
    wr_bank_d  = ~disp_bank_d;
  end

  // Stage 1 capture and stage 2 masking.
  always_comb begin
    s1_valid_d  = accept_c;
    s1_pixel_d  = accept_c ? in_pixel  : s1_pixel_q;
    s1_row_d    = accept_c ? eff_row_c : s1_row_q;
    s1_col_d    = accept_c ? eff_col_c : s1_col_q;
    s1_inside_d = accept_c ? inside_c  : s1_inside_q;

    dimmed_c = '0;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      dimmed_c[ch*CH_W +: CH_W] = s1_pixel_q[ch*CH_W +: CH_W] >> 1;
    end

    wr_en_d  = s1_valid_q;
    wr_row_d = s1_row_q;
    wr_col_d = s1_col_q;
    unique case (mode_sh_q)
      MODE_PASS:     wr_data_d = s1_pixel_q;
      MODE_KEEP_IN:  wr_data_d = s1_inside_q ? s1_pixel_q : '0;
      MODE_KEEP_OUT: wr_data_d = s1_inside_q ? '0 : s1_pixel_q;
      MODE_DIM_OUT:  wr_data_d = s1_inside_q ? s1_pixel_q : dimmed_c;
      default:       wr_data_d = s1_pixel_q;
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_sh_q    <= MODE_PASS;
      roff_sh_q    <= '0;
      coff_sh_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      disp_bank_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_pixel_q   <= '0;
      s1_row_q     <= '0;
      s1_col_q     <= '0;
      s1_inside_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= 1'b1;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_sh_q    <= mode_sh_d;
      roff_sh_q    <= roff_sh_d;
      coff_sh_q    <= coff_sh_d;
      row_q        <= row_d;
      col_q        <= col_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      disp_bank_q  <= disp_bank_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_pixel_q   <= s1_pixel_d;
      s1_row_q     <= s1_row_d;
      s1_col_q     <= s1_col_d;
      s1_inside_q  <= s1_inside_d;
      wr_en_q      <= wr_en_d;
      wr_bank_q    <= wr_bank_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign disp_bank  = disp_bank_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign wr_en      = wr_en_q;
  assign wr_bank    = wr_bank_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_mask_stream_engine.sv
// Directed-sequence bench with randomized pixels/valid, checked against a frame-position reference model.
module tb_mask_stream_engine;

  localparam int unsigned IMG_W  = 60;
  localparam int unsigned IMG_H  = 24;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned PIX_W  = 12;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned MASK_H = 12;
  localparam int FRAME_PIX = int'(IMG_W * IMG_H);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [ROW_W-1:0] mask_row_off;
  logic [COL_W-1:0] mask_col_off;
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             vblank;
  logic             wr_en;
  logic             wr_bank;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [PIX_W-1:0] wr_data;
  logic             disp_bank;
  logic             frame_done;
  logic             sync_err;
  logic             busy;

  mask_stream_engine #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .ROW_W (ROW_W), .COL_W (COL_W),
    .PIX_W (PIX_W), .MASK_W (MASK_W), .MASK_H (MASK_H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .mask_row_off (mask_row_off),
    .mask_col_off (mask_col_off),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sof       (in_sof),
    .in_pixel     (in_pixel),
    .vblank       (vblank),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .disp_bank    (disp_bank),
    .frame_done   (frame_done),
    .sync_err     (sync_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int r;
    int c;
    int d;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q[$];

  // Reference model state: linear pixel position within the frame plus shadowed config.
  int mpos;
  bit pending;
  bit exp_bank;
  bit exp_sync;
  bit need_latch;
  int sh_mode, sh_roff, sh_coff;
  int drain;
  bit auto_sof;
  bit force_sof;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic void mdl_reset();
    q.delete();
    mpos       = 0;
    pending    = 1'b0;
    exp_bank   = 1'b0;
    exp_sync   = 1'b0;
    need_latch = 1'b1;
    drain      = 0;
  endfunction

  function automatic void mdl_accept(input logic [PIX_W-1:0] pix, input logic sof);
    int   r, c, d, p;
    bit   ins;
    exp_t e;
    if (sof) begin
      if (mpos != 0) exp_sync = 1'b1;
      mpos = 0;
    end else if (mpos == 0) begin
      exp_sync = 1'b1;
    end
    if (need_latch) begin
      sh_mode    = int'(mode);
      sh_roff    = int'(mask_row_off);
      sh_coff    = int'(mask_col_off);
      need_latch = 1'b0;
    end
    r   = mpos / int'(IMG_W);
    c   = mpos % int'(IMG_W);
    p   = int'(pix);
    ins = (r >= sh_roff) && (r < sh_roff + int'(MASK_H)) &&
          (c >= sh_coff) && (c < sh_coff + int'(MASK_W));
    case (sh_mode)
      0:       d = p;
      1:       d = ins ? p : 0;
      2:       d = ins ? 0 : p;
      default: d = ins ? p : (p / 512) * 256 + ((p / 32) % 8) * 16 + (p % 16) / 2;
    endcase
    e.cyc = cyc + 2;
    e.r   = r;
    e.c   = c;
    e.d   = d;
    q.push_back(e);
    mpos++;
    if (mpos == FRAME_PIX) begin
      mpos       = 0;
      pending    = 1'b1;
      need_latch = 1'b1;
    end
  endfunction

  // One clock: feed the model with this cycle's transfer, then check outputs just after the edge.
  task automatic tick();
    bit   acc;
    bit   vb_prev;
    exp_t e;
    acc     = rst_n && in_valid && in_ready;
    vb_prev = vblank;
    if (acc) mdl_accept(in_pixel, in_sof);
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() != 0 && (wr_en === 1'b1 || q[0].cyc <= cyc)) begin
      e = q.pop_front();
      chk("wr_en", 32'(wr_en), 32'd1);
      chk("wr_latency", 32'(cyc), 32'(e.cyc));
      chk("wr_row", 32'(wr_row), 32'(e.r));
      chk("wr_col", 32'(wr_col), 32'(e.c));
      chk("wr_data", 32'(wr_data), 32'(e.d));
      chk("wr_bank_on_write", 32'(wr_bank), 32'(!exp_bank));
    end else begin
      chk("wr_idle", 32'(wr_en), 32'd0);
    end
    if (frame_done === 1'b1) begin
      chk("swap_ready", {29'd0, pending, q.size() == 0, vb_prev}, 32'd7);
      pending  = 1'b0;
      drain    = 0;
      exp_bank = !exp_bank;
    end else if (pending && q.size() == 0 && vb_prev) begin
      drain++;
      chk("swap_delay", 32'(drain <= 2), 32'd1);
    end
    if (pending) chk("ready_in_wait", 32'(in_ready), 32'd0);
    chk("disp_bank", 32'(disp_bank), 32'(exp_bank));
    chk("wr_bank", 32'(wr_bank), 32'(!exp_bank));
    chk("sync_err", 32'(sync_err), 32'(exp_sync));
  endtask

  // Push n accepted pixels (pix<0: random data) with valid asserted vprob% of cycles.
  task automatic stream(input int n, input int pix, input int vprob, input int budget);
    int  sent  = 0;
    int  spent = 0;
    bit  acc;
    while (sent < n && spent < budget) begin
      in_valid = ($urandom_range(0, 99) < vprob);
      in_pixel = (pix < 0) ? PIX_W'($urandom) : PIX_W'(pix);
      in_sof   = force_sof ? 1'b1 : (auto_sof && mpos == 0);
      acc      = rst_n && in_valid && in_ready;
      tick();
      spent++;
      if (acc) begin
        sent++;
        force_sof = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("stream_budget", 32'(sent), 32'(n));
  endtask

  task automatic wait_swap(input int limit);
    int t = 0;
    while (pending && t < limit) begin
      tick();
      t++;
    end
    chk("swap_seen", 32'(pending), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    mode         = 2'd0;
    mask_row_off = '0;
    mask_col_off = '0;
    in_valid     = 1'b0;
    in_sof       = 1'b0;
    in_pixel     = '0;
    vblank       = 1'b1;
    auto_sof     = 1'b1;
    force_sof    = 1'b0;
    mdl_reset();
    tick();
    tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_disp_bank", 32'(disp_bank), 32'd0);
    chk("rst_wr_bank", 32'(wr_bank), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Frame A: pass mode, all-FFF, continuous valid; config changed mid-frame must not apply.
    mode = 2'd0;
    en   = 1'b1;
    tick();
    tick();
    chk("active_busy", 32'(busy), 32'd1);
    chk("active_in_ready", 32'(in_ready), 32'd1);
    stream(700, 'hFFF, 100, 800);
    mode         = 2'd1;
    mask_row_off = ROW_W'(10);
    mask_col_off = COL_W'(20);
    stream(FRAME_PIX - 700, 'hFFF, 100, 1000);
    wait_swap(20);
    chk("frameA_disp_bank", 32'(disp_bank), 32'd1);

    // Frame B: keep-inside at (10,20), ABC data, vblank held low at the end.
    vblank = 1'b0;
    stream(FRAME_PIX / 2, 'hABC, 70, 2000);
    mode         = 2'd3;
    mask_row_off = ROW_W'(22);
    mask_col_off = COL_W'(56);
    stream(FRAME_PIX - FRAME_PIX / 2, 'hABC, 70, 2000);
    repeat (20) tick();
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    chk("hold_disp_bank", 32'(disp_bank), 32'd1);
    chk("hold_busy", 32'(busy), 32'd1);
    vblank = 1'b1;
    wait_swap(4);
    chk("frameB_disp_bank", 32'(disp_bank), 32'd0);

    // Frame C: dim-outside with a window clipping the bottom-right corner; stray SOF at (5,7).
    stream(5 * int'(IMG_W) + 7, 'hABC, 70, 1000);
    force_sof = 1'b1;
    stream(1, 'hABC, 70, 50);
    chk("sof_mid_sync_err", 32'(sync_err), 32'd1);
    stream(700, -1, 70, 1500);
    mode         = 2'd2;
    mask_row_off = ROW_W'(3);
    mask_col_off = COL_W'(5);
    stream(FRAME_PIX - 701, 'hABC, 70, 2000);
    wait_swap(20);
    chk("frameC_disp_bank", 32'(disp_bank), 32'd1);

    // Frame D: keep-outside, en dropped mid-frame so the engine idles after the swap.
    stream(500, -1, 70, 1000);
    en = 1'b0;
    stream(FRAME_PIX - 500, -1, 70, 2000);
    wait_swap(20);
    repeat (3) tick();
    chk("endrop_busy", 32'(busy), 32'd0);
    chk("endrop_in_ready", 32'(in_ready), 32'd0);
    chk("endrop_disp_bank", 32'(disp_bank), 32'd0);

    // Frame E: reset asserted at pixel 1000.
    mode         = 2'd1;
    mask_row_off = ROW_W'(0);
    mask_col_off = COL_W'(0);
    en           = 1'b1;
    stream(1000, -1, 80, 1500);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    mdl_reset();
    tick();
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_disp_bank", 32'(disp_bank), 32'd0);
    chk("midrst_sync_err", 32'(sync_err), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();

    // First pixel of a frame without SOF still lands at (0,0) but flags sync_err.
    auto_sof = 1'b0;
    stream(1, -1, 100, 10);
    auto_sof = 1'b1;
    chk("nosof_sync_err", 32'(sync_err), 32'd1);
    stream(200, -1, 60, 600);
    repeat (4) tick();
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
